// File: rtl/cycloneive_demux14_reg.sv
// cycloneive_demux14_reg: 1-to-4 registered demultiplexer with per-lane
// valid/ack handshake. A word is accepted when valid && ready and lands in
// the lane picked by s one clock later. A lane stays full until its consumer
// acks it, and it can be refilled on the same edge as the ack without a bubble.
//
// Optional feature: define CYCLONEIVE_DEMUX_STALL_CNT_EN to build a saturating
// 8-bit counter of stalled requests on stall_cnt. Without it, stall_cnt is
// tied to zero.
module cycloneive_demux14_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 ena,
    input  logic [WIDTH-1:0]     datain,
    input  logic [1:0]           s,
    input  logic                 valid,
    output logic                 ready,
    output logic [4*WIDTH-1:0]   mo,
    output logic [3:0]           mo_valid,
    input  logic [3:0]           mo_ack,
    output logic [7:0]           stall_cnt
);

    localparam int unsigned LANES   = 4;
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic accept;

    // Selected lane can take a word if it is empty or being drained this cycle
    always_comb begin
        ready  = ena & (~mo_valid[s] | mo_ack[s]);
        accept = valid & ready;
    end

    // Lane data and valid flags; a refill wins over a same-cycle consume
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mo       <= '0;
            mo_valid <= '0;
        end else if (ena) begin
            for (int unsigned n = 0; n < LANES; n++) begin
                if (accept && (s == 2'(n))) begin
                    mo[n*WIDTH +: WIDTH] <= datain;
                    mo_valid[n]          <= 1'b1;
                end else if (mo_valid[n] && mo_ack[n]) begin
                    mo_valid[n]          <= 1'b0;
                end
            end
        end
    end

`ifdef CYCLONEIVE_DEMUX_STALL_CNT_EN
    logic stall;

    // A stall is a live request that the selected lane cannot take
    always_comb begin
        stall = ena & valid & ~ready;
    end

    // Saturating stall counter
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`else
    // Counter not built
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cycloneive_demux14_reg.sv
// Testbench for cycloneive_demux14_reg: directed vectors, scoreboard checking.
// The driver pushes the expected registered state for each cycle into a queue,
// and the monitor pops and compares it just after each rising edge.
module tb_cycloneive_demux14_reg;

`ifdef CYCLONEIVE_DEMUX_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [4*WIDTH-1:0] mo;
        logic [3:0]         mv;
        logic [7:0]         sc;
        int                 id;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 clrn;
    logic                 ena;
    logic [WIDTH-1:0]     datain;
    logic [1:0]           s;
    logic                 valid;
    logic                 ready;
    logic [4*WIDTH-1:0]   mo;
    logic [3:0]           mo_valid;
    logic [3:0]           mo_ack;
    logic [7:0]           stall_cnt;

    exp_t q[$];
    int   tests  = 0;
    int   errors = 0;
    int   step_id = 0;
    int   exp_stall = 0;

    cycloneive_demux14_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ena       (ena),
        .datain    (datain),
        .s         (s),
        .valid     (valid),
        .ready     (ready),
        .mo        (mo),
        .mo_valid  (mo_valid),
        .mo_ack    (mo_ack),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Monitor: compare registered outputs against the scoreboard after each edge
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("mo",        e.id, 32'(mo),        32'(e.mo));
            check("mo_valid",  e.id, 32'(mo_valid),  32'(e.mv));
            check("stall_cnt", e.id, 32'(stall_cnt), 32'(e.sc));
        end
    end

    // One clock of stimulus with hand-computed ready and next-cycle lane state
    task automatic step(input bit e, input bit v, input logic [1:0] sel,
                        input logic [7:0] d, input logic [3:0] ack,
                        input bit exp_rdy, input logic [31:0] exp_mo,
                        input logic [3:0] exp_mv);
        exp_t x;
        @(negedge clk);
        ena = e; valid = v; s = sel; datain = d; mo_ack = ack;
        #1;
        step_id++;
        check("ready", step_id, 32'(ready), 32'(exp_rdy));
        if (STALL_EN && e && v && !exp_rdy && exp_stall < 255) exp_stall++;
        x.mo = exp_mo; x.mv = exp_mv; x.sc = 8'(exp_stall); x.id = step_id;
        q.push_back(x);
        @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0; ena = 1'b0; valid = 1'b0; s = 2'd0; datain = '0; mo_ack = '0;
        #12;
        check("reset mo",        0, 32'(mo),        32'h0);
        check("reset mo_valid",  0, 32'(mo_valid),  32'h0);
        check("reset stall_cnt", 0, 32'(stall_cnt), 32'h0);
        @(negedge clk);
        clrn = 1'b1;

        // Accept into lane 2, then lane 1
        step(1, 1, 2'd2, 8'hA5, 4'b0000, 1, 32'h00A5_0000, 4'b0100);
        step(1, 1, 2'd1, 8'h11, 4'b0000, 1, 32'h00A5_1100, 4'b0110);
        // Lane 1 full, no ack: stalls, lane holds 0x11
        for (int i = 0; i < 3; i++)
            step(1, 1, 2'd1, 8'h22, 4'b0000, 0, 32'h00A5_1100, 4'b0110);
        // Fill lane 3, then refill it on the same edge as its ack
        step(1, 1, 2'd3, 8'h33, 4'b0000, 1, 32'h33A5_1100, 4'b1110);
        step(1, 1, 2'd3, 8'h44, 4'b1000, 1, 32'h44A5_1100, 4'b1110);
        step(1, 1, 2'd0, 8'h55, 4'b0000, 1, 32'h44A5_1155, 4'b1111);
        // Drain lanes 1 and 3; data holds, only valid flags clear
        step(1, 0, 2'd0, 8'h00, 4'b1010, 0, 32'h44A5_1155, 4'b0101);
        // Ack lane 0 while requesting full lane 2: lane 0 empties, no load
        step(1, 1, 2'd2, 8'h66, 4'b0001, 0, 32'h44A5_1155, 4'b0100);
        // Ack on an empty lane is ignored
        step(1, 0, 2'd1, 8'h00, 4'b0010, 1, 32'h44A5_1155, 4'b0100);
        // Consume lane 2 and load lane 0 on the same edge
        step(1, 1, 2'd0, 8'h77, 4'b0100, 1, 32'h44A5_1177, 4'b0001);
        // Clock enable low freezes everything
        for (int i = 0; i < 3; i++)
            step(0, 1, 2'd0, 8'h88, 4'b1111, 0, 32'h44A5_1177, 4'b0001);
        // Long stall on full lane 0: counter saturates when built
        for (int i = 0; i < 300; i++)
            step(1, 1, 2'd0, 8'h99, 4'b0000, 0, 32'h44A5_1177, 4'b0001);

        // Asynchronous clear in the middle of the low clock phase
        @(negedge clk);
        valid = 1'b0; mo_ack = '0;
        #2;
        clrn = 1'b0;
        #1;
        check("async mo",        900, 32'(mo),        32'h0);
        check("async mo_valid",  900, 32'(mo_valid),  32'h0);
        check("async stall_cnt", 900, 32'(stall_cnt), 32'h0);
        check("async ready",     900, 32'(ready),     32'h1);
        exp_stall = 0;
        @(posedge clk);
        #2;
        clrn = 1'b1;

        // First edge after clear accepts
        step(1, 1, 2'd1, 8'h99, 4'b0000, 1, 32'h0000_9900, 4'b0010);

        @(negedge clk);
        valid = 1'b0;
        @(posedge clk);
        #3;
        check("scoreboard drained", 999, 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
